manchester_tx: RTL

MANCHESTER_TX -- requirements
Module: manchester_tx

---
 rtl/manchester_pkg.sv | 18 +
 rtl/bit_timer.sv | 45 ++++
 rtl/manchester_tx.sv | 107 ++++++++++
 3 files changed

// File: rtl/manchester_pkg.sv
// Shared Manchester line definitions: FSM state, frame start bit and half-bit levels.
// Imported by the transmitter and by the matching demodulator.
package manchester_pkg;

   typedef enum logic {StIdle, StSend} tx_state_e;

   localparam logic START_BIT       = 1'b1;
   // Line levels for a '1' bit; a '0' bit uses the inverse of each.
   localparam logic ONE_FIRST_HALF  = 1'b0;
   localparam logic ONE_SECOND_HALF = 1'b1;

   function automatic logic half_level(input logic bit_val, input logic second_half);
      logic lvl;
      lvl = second_half ? ONE_SECOND_HALF : ONE_FIRST_HALF;
      return bit_val ? lvl : ~lvl;
   endfunction

endpackage

// File: rtl/bit_timer.sv
// Half-bit timer: counts CLKS_PER_HALF_BIT cycles per half and strobes on the last cycle of
// each half (half_end_o) and of each full bit (bit_end_o). Held at zero while run_i is low.
module bit_timer #(
   parameter int unsigned CLKS_PER_HALF_BIT = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic run_i,
   output logic half_end_o,
   output logic bit_end_o
);

   localparam int unsigned CntW = (CLKS_PER_HALF_BIT > 1) ? $clog2(CLKS_PER_HALF_BIT) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_HALF_BIT - 1);

   logic [CntW-1:0] cnt_q, cnt_d;
   logic            phase_q, phase_d;

   always_comb begin
      half_end_o = run_i && (cnt_q == CntMax);
      bit_end_o  = half_end_o && phase_q;
      cnt_d      = cnt_q;
      phase_d    = phase_q;
      if (!run_i) begin
         cnt_d   = '0;
         phase_d = 1'b0;
      end else if (half_end_o) begin
         cnt_d   = '0;
         phase_d = ~phase_q;
      end else begin
         cnt_d = cnt_q + CntW'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q   <= '0;
         phase_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
      end
   end

endmodule

// File: rtl/manchester_tx.sv
// Manchester transmitter: frames each accepted word as a '1' start bit plus WORD_WIDTH data
// bits MSB first, with a registered line output and a bit clock high in each second half.
module manchester_tx
   import manchester_pkg::*;
#(
   parameter int unsigned WORD_WIDTH        = 8,
   parameter int unsigned CLKS_PER_HALF_BIT = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [WORD_WIDTH-1:0] data_in,
   input  logic                  data_valid,
   output logic                  data_ready,
   output logic                  out,
   output logic                  output_clk,
   output logic                  next_word,
   output logic                  busy
);

   localparam int unsigned BitW = $clog2(WORD_WIDTH + 1);
   localparam logic [BitW-1:0] LastBit = BitW'(WORD_WIDTH);

   tx_state_e           state_q, state_d;
   logic [WORD_WIDTH:0] shreg_q, shreg_d;
   logic [BitW-1:0]     bit_cnt_q, bit_cnt_d;
   logic                out_q, out_d;
   logic                oclk_q, oclk_d;
   logic                half_end, bit_end;
   logic                frame_end, xfer;

   bit_timer #(
      .CLKS_PER_HALF_BIT(CLKS_PER_HALF_BIT)
   ) u_bit_timer (
      .clk_i     (clk),
      .rst_i     (reset),
      .run_i     (state_q == StSend),
      .half_end_o(half_end),
      .bit_end_o (bit_end)
   );

   assign frame_end = (state_q == StSend) && bit_end && (bit_cnt_q == LastBit);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= StIdle;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (xfer) state_d = StSend;
         StSend:  if (frame_end && !xfer) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      busy       = (state_q == StSend);
      data_ready = !reset && ((state_q == StIdle) || frame_end);
      next_word  = data_valid && data_ready;
      xfer       = next_word;
   end

   // out/output_clk are registered, so each branch computes the level of the coming cycle.
   always_comb begin
      shreg_d   = shreg_q;
      bit_cnt_d = bit_cnt_q;
      out_d     = out_q;
      oclk_d    = oclk_q;
      if (xfer) begin
         shreg_d   = {START_BIT, data_in};
         bit_cnt_d = '0;
         out_d     = half_level(START_BIT, 1'b0);
         oclk_d    = 1'b0;
      end else if (frame_end || (state_q == StIdle)) begin
         bit_cnt_d = '0;
         out_d     = 1'b0;
         oclk_d    = 1'b0;
      end else if (bit_end) begin
         shreg_d   = {shreg_q[WORD_WIDTH-1:0], 1'b0};
         bit_cnt_d = bit_cnt_q + BitW'(1);
         out_d     = half_level(shreg_q[WORD_WIDTH-1], 1'b0);
         oclk_d    = 1'b0;
      end else if (half_end) begin
         out_d  = half_level(shreg_q[WORD_WIDTH], 1'b1);
         oclk_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shreg_q   <= '0;
         bit_cnt_q <= '0;
         out_q     <= 1'b0;
         oclk_q    <= 1'b0;
      end else begin
         shreg_q   <= shreg_d;
         bit_cnt_q <= bit_cnt_d;
         out_q     <= out_d;
         oclk_q    <= oclk_d;
      end
   end

   assign out        = out_q;
   assign output_clk = oclk_q;

endmodule
